// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- MEM pipeline stage with a request/acknowledge data-memory port
//
// Turns an EX/MEM load or store into exactly one data-memory request, stalls
// the upstream pipeline while the access is outstanding, and loads the MEM/WB
// pipeline register. Misaligned or read+write accesses are dropped as bubbles.
// Accesses with no acknowledge within TIMEOUT WAIT cycles are also dropped as
// bubbles. Both cases set a sticky error flag.
//
// Parameters
//   TIMEOUT       maximum WAIT cycles before an access is abandoned (1..255)
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous reset, active low
//   wb_i          EX/MEM writeback controls {RegWrite, MemtoReg}
//   memread_i     load request
//   memwrite_i    store request
//   addr_i        ALU result / byte address
//   wdata_i       store data
//   writeaddr_i   destination register
//   dmem_req_o    data-memory request (held until ack or timeout)
//   dmem_we_o     data-memory write enable
//   dmem_addr_o   data-memory address
//   dmem_wdata_o  data-memory store data
//   dmem_rdata_i  data-memory load data
//   dmem_ack_i    one-cycle completion pulse
//   stall_o       hold EX/MEM and all upstream stages (combinational)
//   wb_o          MEM/WB writeback controls
//   result_o      MEM/WB ALU result
//   rdata_o       MEM/WB load data (0 for non-loads)
//   writeaddr_o   MEM/WB destination register
//   err_o         sticky error flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  writeaddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic [1:0]  wb_o,
  output logic [31:0] result_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  writeaddr_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter value seen during the final permitted WAIT cycle.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_stall;

  logic [7:0]  r_cnt;
  logic        r_timed_out;
  logic [31:0] r_rdata_cap;

  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;

  logic [1:0]  r_wb;
  logic [31:0] r_result;
  logic [31:0] r_rdata;
  logic [4:0]  r_writeaddr;
  logic        r_err;

  logic        w_memop;
  logic        w_illegal;
  logic        w_last;

  assign w_memop   = memread_i | memwrite_i;
  assign w_illegal = (memread_i & memwrite_i) |
                     (w_memop & (addr_i[1:0] != 2'b00));
  assign w_last    = (r_cnt == LAST_CNT);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and stall
  // -------------------------------------------------------------------------
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_memop && !w_illegal) begin
          w_next  = S_WAIT;
          w_stall = 1'b1;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        // An ack on the last permitted cycle still completes normally.
        if (dmem_ack_i || w_last) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (!rst_i) begin
      w_stall = 1'b0;
    end
  end

  assign stall_o = w_stall;

  // -------------------------------------------------------------------------
  // Memory port, timeout counter and MEM/WB register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt        <= '0;
      r_timed_out  <= 1'b0;
      r_rdata_cap  <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_wb         <= '0;
      r_result     <= '0;
      r_rdata      <= '0;
      r_writeaddr  <= '0;
      r_err        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_illegal) begin
            // Dropped instruction: retire as a bubble and flag it.
            r_wb        <= 2'b00;
            r_result    <= addr_i;
            r_rdata     <= '0;
            r_writeaddr <= writeaddr_i;
            r_err       <= 1'b1;
          end else if (w_memop) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= memwrite_i;
            r_dmem_addr  <= addr_i;
            r_dmem_wdata <= wdata_i;
            r_cnt        <= '0;
            r_timed_out  <= 1'b0;
            r_rdata_cap  <= '0;
            r_wb         <= 2'b00;
          end else begin
            r_wb        <= wb_i;
            r_result    <= addr_i;
            r_rdata     <= '0;
            r_writeaddr <= writeaddr_i;
          end
        end
        S_WAIT: begin
          r_wb  <= 2'b00;
          r_cnt <= r_cnt + 8'd1;
          if (dmem_ack_i) begin
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_rdata_cap <= r_dmem_we ? '0 : dmem_rdata_i;
          end else if (w_last) begin
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_timed_out <= 1'b1;
            r_err       <= 1'b1;
          end
        end
        S_RESP: begin
          // EX/MEM still holds the instruction that made the access.
          r_wb        <= r_timed_out ? 2'b00 : wb_i;
          r_result    <= addr_i;
          r_rdata     <= r_rdata_cap;
          r_writeaddr <= writeaddr_i;
          r_cnt       <= '0;
          r_timed_out <= 1'b0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign dmem_req_o   = r_dmem_req;
  assign dmem_we_o    = r_dmem_we;
  assign dmem_addr_o  = r_dmem_addr;
  assign dmem_wdata_o = r_dmem_wdata;
  assign wb_o         = r_wb;
  assign result_o     = r_result;
  assign rdata_o      = r_rdata;
  assign writeaddr_o  = r_writeaddr;
  assign err_o        = r_err;

endmodule
